// File: rtl/conv1_fmap_sink_pkg.sv
// Shared conv1/NPU definitions: layer geometry defaults, sink FSM states and
// the requantization helpers reused by later layers.
package npu_pkg;

    localparam int OUT1_H_DEF = 14;
    localparam int OUT1_W_DEF = 13;
    localparam int CHAN_DEF   = 10;
    localparam int TOTAL      = OUT1_H_DEF * OUT1_W_DEF * CHAN_DEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    // Rounded right shift of a non-negative accumulator. The sum is kept at
    // 25 bits so the rounding offset cannot overflow.
    function automatic logic [24:0] requant_raw(input logic signed [23:0] x,
                                                input int                 sh);
        logic [24:0] t;
        t = {1'b0, x};
        if (sh > 0) begin
            t = t + (25'd1 << (sh - 1));
        end
        return t >> sh;
    endfunction

    function automatic logic [7:0] requant(input logic signed [23:0] x,
                                           input int                 sh);
        logic [24:0] r;
        if (x[23]) begin
            return 8'd0;
        end
        r = requant_raw(x, sh);
        return (r > 25'd255) ? 8'hFF : r[7:0];
    endfunction

    function automatic logic requant_sat(input logic signed [23:0] x,
                                         input int                 sh);
        return !x[23] && (requant_raw(x, sh) > 25'd255);
    endfunction

endpackage

// File: rtl/conv1_fmap_sink_ram.sv
// Feature-map buffer: one write port, one synchronous read port whose output
// register only changes on a read, so it holds the last value read.
module fmap_ram #(
    parameter int DEPTH = 1820,
    parameter int AW    = 11
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/conv1_fmap_sink.sv
// conv1 result sink: ReLU + rounding requantization into an 8-bit feature-map
// buffer, readable once a full frame is written. CONV1_SINK_SATCNT_EN adds o_sat_cnt.
module conv1_fmap_sink
    import npu_pkg::*;
#(
    parameter int OUT1_H = OUT1_H_DEF,
    parameter int OUT1_W = OUT1_W_DEF,
    parameter int CHAN   = CHAN_DEF,
    parameter int SHIFT  = 8,
    parameter int AW     = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_in_valid,
    input  logic signed [23:0]   i_in_pixel,
    input  logic [AW-1:0]        i_in_addr,
    input  logic                 i_rd_en,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [7:0]           o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_fmap_ready,
    output logic                 o_addr_err,
    output logic                 o_busy
`ifdef CONV1_SINK_SATCNT_EN
    ,
    output logic [AW-1:0]        o_sat_cnt
`endif
);

    localparam int              TOTAL_L = OUT1_H * OUT1_W * CHAN;
    // One extra bit so a depth of exactly 2**AW still compares correctly.
    localparam logic [AW:0]     TOTAL_X = (AW+1)'(TOTAL_L);
    localparam logic [AW-1:0]   LAST_A  = AW'(TOTAL_L - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic          r_addr_err;
    logic          r_rd_valid;
    logic          r_rd_zero;
    logic          w_start_ok;
    logic          w_wr_in;
    logic          w_wr_ok;
    logic          w_wr_bad;
    logic          w_rd_acc;
    logic          w_rd_ok;
    logic [7:0]    w_q;
    logic [7:0]    w_ram_q;

    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_FULL));
    assign w_wr_in    = (r_state == S_FILL) && i_in_valid;
    assign w_wr_ok    = w_wr_in && ({1'b0, i_in_addr} < TOTAL_X);
    assign w_wr_bad   = w_wr_in && !({1'b0, i_in_addr} < TOTAL_X);
    assign w_rd_acc   = (r_state == S_FULL) && i_rd_en;
    assign w_rd_ok    = w_rd_acc && ({1'b0, i_rd_addr} < TOTAL_X);
    assign w_q        = requant(i_in_pixel, SHIFT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b0;
        o_fmap_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                o_busy = 1'b1;
                if (w_wr_ok && (r_cnt == LAST_A)) w_state_nxt = S_FULL;
            end
            S_FULL: begin
                o_fmap_ready = 1'b1;
                if (i_start) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_addr_err <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            if (w_start_ok) begin
                r_cnt <= '0;
            end else if (w_wr_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A bad read in the same cycle as start still flags the new frame.
            if (w_wr_bad || (w_rd_acc && !w_rd_ok)) begin
                r_addr_err <= 1'b1;
            end else if (w_start_ok) begin
                r_addr_err <= 1'b0;
            end

            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_zero <= !w_rd_ok;
            end
        end
    end

    fmap_ram #(
        .DEPTH (TOTAL_L),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok),
        .i_waddr (i_in_addr),
        .i_wdata (w_q),
        .i_re    (w_rd_ok),
        .i_raddr (i_rd_addr),
        .o_rdata (w_ram_q)
    );

    assign o_rd_data  = r_rd_zero ? 8'd0 : w_ram_q;
    assign o_rd_valid = r_rd_valid;
    assign o_addr_err = r_addr_err;

`ifdef CONV1_SINK_SATCNT_EN
    logic [AW-1:0] r_sat_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_start_ok) begin
            r_sat_cnt <= '0;
        end else if (w_wr_ok && requant_sat(i_in_pixel, SHIFT) && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign o_sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_conv1_fmap_sink.sv
// Directed bench for conv1_fmap_sink: full frames, quantization corners, address
// errors, read latency, start/read overlap and mid-frame reset.
module tb_conv1_fmap_sink;

    localparam int AW    = 11;
    localparam int TOTAL = 1820;

    typedef struct {
        logic signed [23:0] pix;
        int                 q;
        bit                 sat;
    } qvec_t;

    typedef struct {
        int a;
        int e;
    } rvec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [23:0] in_pixel = '0;
    logic [AW-1:0]      in_addr = '0;
    logic               rd_en = 1'b0;
    logic [AW-1:0]      rd_addr = '0;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               fmap_ready;
    logic               addr_err;
    logic               busy;
`ifdef CONV1_SINK_SATCNT_EN
    logic [AW-1:0]      sat_cnt;
`endif

    int    total = 0;
    int    bad   = 0;
    int    exp_sat = 0;
    qvec_t qv [6];
    rvec_t rv [12];

    always #5 clk = ~clk;

    conv1_fmap_sink dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .i_in_pixel   (in_pixel),
        .i_in_addr    (in_addr),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_fmap_ready (fmap_ready),
        .o_addr_err   (addr_err),
        .o_busy       (busy)
`ifdef CONV1_SINK_SATCNT_EN
        ,
        .o_sat_cnt    (sat_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic signed [23:0] p);
        in_valid = 1'b1;
        in_addr  = AW'(a);
        in_pixel = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd_check(input string name, input int a, input int e);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en   = 1'b0;
        check({name, "_valid"}, int'(rd_valid), 1);
        check({name, "_data"}, int'(rd_data), e);
    endtask

    // mode 0: pixel = addr*256, mode 1: pixel = (addr%200)*256; 1000..1005 hold corners
    task automatic fill(input int mode, input bit inject, input int first);
        for (int a = first; a < TOTAL; a++) begin
            int                 base;
            logic signed [23:0] p;
            bit                 s;
            base = (mode == 0) ? a : (a % 200);
            p    = 24'(base * 256);
            s    = (base > 255);
            if (a >= 1000 && a < 1006) begin
                p = qv[a-1000].pix;
                s = qv[a-1000].sat;
            end
            if (inject && a == 100) begin
                in_valid = 1'b1;
                in_addr  = AW'(TOTAL);
                in_pixel = 24'sd1000;
                tick();
                in_valid = 1'b0;
                check("oor_write_err", int'(addr_err), 1);
                check("oor_write_busy", int'(busy), 1);
            end
            if (inject && a == 200) begin
                rd_en   = 1'b1;
                rd_addr = '0;
                tick();
                rd_en   = 1'b0;
                check("fill_read_ignored", int'(rd_valid), 0);
            end
            if (a == TOTAL - 1) begin
                check("pre_last_ready", int'(fmap_ready), 0);
                check("pre_last_busy", int'(busy), 1);
            end
            wr(a, p);
            if (s && exp_sat < 2047) exp_sat++;
        end
        check("post_last_ready", int'(fmap_ready), 1);
        check("post_last_busy", int'(busy), 0);
    endtask

    initial begin
        qv[0] = '{24'shFFFFFF, 0,   1'b0};
        qv[1] = '{24'sd127,    0,   1'b0};
        qv[2] = '{24'sd128,    1,   1'b0};
        qv[3] = '{24'sd65407,  255, 1'b0};
        qv[4] = '{24'sd65408,  255, 1'b1};
        qv[5] = '{24'sh7FFFFF, 255, 1'b1};

        rv[0]  = '{5, 5};
        rv[1]  = '{300, 255};
        rv[2]  = '{0, 0};
        rv[3]  = '{255, 255};
        rv[4]  = '{256, 255};
        rv[5]  = '{1819, 255};
        rv[6]  = '{1000, 0};
        rv[7]  = '{1001, 0};
        rv[8]  = '{1002, 1};
        rv[9]  = '{1003, 255};
        rv[10] = '{1004, 255};
        rv[11] = '{1005, 255};

        // reset state
        #12;
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_ready", int'(fmap_ready), 0);
        check("rst_err", int'(addr_err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // idle ignores writes and reads
        in_valid = 1'b1; rd_en = 1'b1;
        tick();
        in_valid = 1'b0; rd_en = 1'b0;
        check("idle_busy", int'(busy), 0);
        check("idle_rd_valid", int'(rd_valid), 0);

        // frame 1 with an out-of-range write and a read during fill
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        fill(0, 1'b1, 0);
        check("f1_err_sticky", int'(addr_err), 1);
`ifdef CONV1_SINK_SATCNT_EN
        check("f1_sat_cnt", int'(sat_cnt), exp_sat);
`endif
        check("f1_rd_valid_idle", int'(rd_valid), 0);

        // back-to-back reads, one result per cycle, one cycle latency
        for (int i = 0; i < 12; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(rv[i].a);
            tick();
            check($sformatf("rd_valid_%0d", rv[i].a), int'(rd_valid), 1);
            check($sformatf("rd_data_%0d", rv[i].a), int'(rd_data), rv[i].e);
        end
        rd_en = 1'b0;
        tick();
        check("rd_valid_drop", int'(rd_valid), 0);
        check("rd_data_hold", int'(rd_data), 255);

        // start and read in the same cycle: read completes, new fill begins
        start   = 1'b1;
        rd_en   = 1'b1;
        rd_addr = AW'(10);
        tick();
        start = 1'b0;
        rd_en = 1'b0;
        check("ovl_rd_valid", int'(rd_valid), 1);
        check("ovl_rd_data", int'(rd_data), 10);
        check("ovl_busy", int'(busy), 1);
        check("ovl_ready", int'(fmap_ready), 0);
        check("ovl_err_clear", int'(addr_err), 0);
        exp_sat = 0;
        wr(0, 24'sd0);
        fill(1, 1'b0, 1);
`ifdef CONV1_SINK_SATCNT_EN
        check("f2_sat_cnt", int'(sat_cnt), 2);
`endif
        rd_check("f2_rd10", 10, 10);
        rd_check("f2_rd250", 250, 50);
        rd_check("f2_rd1819", 1819, 19);
        rd_check("f2_rd1002", 1002, 1);
        check("f2_err_clean", int'(addr_err), 0);
        rd_check("f2_rd_oor", 2047, 0);
        check("f2_rd_oor_err", int'(addr_err), 1);

        // async reset after 500 writes of a new frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int a = 0; a < 500; a++) begin
            wr(a, 24'(a * 256));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_ready", int'(fmap_ready), 0);
        check("arst_err", int'(addr_err), 0);
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_rd_data", int'(rd_data), 0);
`ifdef CONV1_SINK_SATCNT_EN
        check("arst_sat_cnt", int'(sat_cnt), 0);
`endif
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", int'(fmap_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_sat = 0;
        fill(0, 1'b0, 0);
`ifdef CONV1_SINK_SATCNT_EN
        check("f3_sat_cnt", int'(sat_cnt), exp_sat);
`endif
        rd_check("f3_rd5", 5, 5);
        rd_check("f3_rd300", 300, 255);
        rd_check("f3_rd1002", 1002, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv1_fmap_sink.md
Name: conv1_fmap_sink

Overview:
- Receiving end of the conv1 result stream: accepts one 24-bit signed accumulator per cycle with its linear output address (channel-major, row-major within channel).
- Applies ReLU, rounding right-shift requantization and unsigned 8-bit saturation, then stores the pixel in an on-chip feature-map buffer.
- Once every address of the frame has been written, the buffer is exposed through a 1-cycle-latency read port to the next layer (pool/conv2).

Parameters:
- OUT1_H, 14, conv1 output rows
- OUT1_W, 13, conv1 output columns
- CHAN, 10, conv1 output channels
- SHIFT, 8, requantization right-shift amount (0..16)
- AW, 11, address width; 2**AW must be >= OUT1_H*OUT1_W*CHAN

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a new frame (honoured only in S_IDLE or S_FULL)
- in_valid  in  1  in_pixel/in_addr valid this cycle
- in_pixel  in  24  signed conv1 accumulator
- in_addr  in  AW  linear address of in_pixel
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  8  requantized pixel; valid when rd_valid=1
- rd_valid  out  1  rd_data valid (one cycle after an accepted rd_en)
- fmap_ready  out  1  buffer fully written, readable
- addr_err  out  1  sticky: out-of-range write or read seen since start
- busy  out  1  high in S_FILL

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE; rd_data=0, rd_valid=0, fmap_ready=0, addr_err=0, busy=0; write counter=0. Buffer contents are not reset.
- TOTAL = OUT1_H*OUT1_W*CHAN (1820 at defaults).
- S_IDLE: ignores in_valid and rd_en. start -> S_FILL next cycle, counter=0, addr_err=0.
- S_FILL: busy=1. Each cycle with in_valid=1 and in_addr<TOTAL: write q(in_pixel) at in_addr and increment counter. in_addr>=TOTAL: drop the write, set addr_err, no count. When the accepted write makes counter==TOTAL -> S_FULL next cycle. Duplicate addresses count twice; the producer guarantees each address exactly once. rd_en is ignored (rd_valid=0). start is ignored.
- S_FULL: fmap_ready=1; in_valid is ignored. rd_en with rd_addr<TOTAL: rd_data=mem[rd_addr] and rd_valid=1 on the next cycle. rd_en with rd_addr>=TOTAL: rd_data=0, rd_valid=1, addr_err set. Back-to-back reads give one result per cycle. start -> S_FILL (fmap_ready drops next cycle); a read accepted in the same cycle as start still completes.
- rd_valid=0 in any cycle without an accepted read in the previous cycle; rd_data holds its last value.
- Requantization q(x), combinational on the write path:
  - x<0 -> 0.
  - Otherwise r = (x + (SHIFT>0 ? 2**(SHIFT-1) : 0)) >> SHIFT, computed 25-bit to avoid overflow.
  - r>255 -> 255; otherwise r[7:0].
- Reset mid-frame returns to S_IDLE. The buffer holds stale data; fmap_ready stays 0 until a full new frame is written.

Optional Feature:
- Macro CONV1_SINK_SATCNT_EN.
- Defined: adds output sat_cnt [AW-1:0]. It clears on start and on reset, and increments on each accepted write where r>255 (clipped to 255). It saturates at all-ones.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package npu_pkg: OUT1_H/OUT1_W/CHAN defaults, TOTAL localparam, state enum (S_IDLE, S_FILL, S_FULL), and a requant function (24-bit signed, SHIFT) -> 8-bit unsigned, reused by later layers.
- One sub-module fmap_ram: single write port, single synchronous read port, depth TOTAL, width 8.

Test Plan:
- Reset, then start, then 1820 writes with in_pixel=addr*256 (SHIFT=8) in order -> busy for 1820 cycles; fmap_ready=1 one cycle after the last write; reading addr 5 gives rd_data=5 and addr 300 gives 255; rd_valid lags rd_en by exactly 1 cycle.
- Quantization corners at SHIFT=8: -1 -> 0; 127 -> 0; 128 -> 1; 65407 -> 255; 65408 -> 255 (sat); 0x7FFFFF -> 255. With CONV1_SINK_SATCNT_EN, sat_cnt=2.
- Out-of-range write in_addr=1820 mid-fill -> addr_err=1, counter unchanged; 1820 valid writes still needed for fmap_ready.
- Read during S_FILL (rd_en=1, addr 0) -> rd_valid stays 0. Read in S_FULL with rd_addr=2047 -> rd_valid=1, rd_data=0, addr_err=1.
- Pull rst_n low after 500 writes -> all outputs 0 immediately (async). A new start plus a full frame gives correct data.
- In S_FULL, start and rd_en(addr 10) in the same cycle -> rd_valid=1 with the old mem[10] next cycle, busy=1, fmap_ready=0; a new in_valid write is accepted in that same next cycle.
